// File: rtl/demo_top.sv
// Self-contained stream demo: an incrementing producer feeds a periodically stalling
// consumer that tracks transfer count, checksum, last word and ordering errors.
module demo_top #(
  parameter int DATA_WIDTH   = 8,
  parameter int SUM_WIDTH    = 16,
  parameter int CNT_WIDTH    = 16,
  parameter int STALL_PERIOD = 4
) (
  input  logic                  i_clk,
  input  logic                  i_async_rst_n,
  output logic [CNT_WIDTH-1:0]  o_xfer_cnt,
  output logic [SUM_WIDTH-1:0]  o_sum,
  output logic [DATA_WIDTH-1:0] o_last_data,
  output logic                  o_err
);

  localparam int PHASE_WIDTH = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [PHASE_WIDTH-1:0] PHASE_LAST = PHASE_WIDTH'(STALL_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX    = {CNT_WIDTH{1'b1}};

  logic                   p_valid_reg;
  logic [DATA_WIDTH-1:0]  p_data_reg;
  logic [PHASE_WIDTH-1:0] phase_reg;
  logic [DATA_WIDTH-1:0]  exp_reg;

  // Link between producer and consumer.
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  xfer;

  assign valid = p_valid_reg;
  assign data  = p_data_reg;
  assign ready = (phase_reg != PHASE_LAST);
  assign xfer  = valid && ready;

  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      p_valid_reg <= 1'b0;
      p_data_reg  <= '0;
    end else begin
      p_valid_reg <= 1'b1;
      if (xfer) begin
        p_data_reg <= p_data_reg + DATA_WIDTH'(1);
      end
    end
  end

  // Ready pattern: one stall cycle at the end of every period.
  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      phase_reg <= '0;
    end else if (phase_reg == PHASE_LAST) begin
      phase_reg <= '0;
    end else begin
      phase_reg <= phase_reg + PHASE_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      o_xfer_cnt  <= '0;
      o_sum       <= '0;
      o_last_data <= '0;
      o_err       <= 1'b0;
      exp_reg     <= '0;
    end else if (xfer) begin
      if (o_xfer_cnt != CNT_MAX) begin
        o_xfer_cnt <= o_xfer_cnt + CNT_WIDTH'(1);
      end
      o_sum       <= o_sum + SUM_WIDTH'(data);
      o_last_data <= data;
      // exp wraps exactly like the producer, so rollover is not a mismatch.
      if (data != exp_reg) begin
        o_err <= 1'b1;
      end
      exp_reg <= exp_reg + DATA_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_demo_top.sv
// Directed bench for demo_top: default instance plus a DATA_WIDTH=2 instance for wrap-around.
module tb_demo_top;

  logic r_clk;
  logic rst_n;

  logic [15:0] cnt_a, sum_a;
  logic [7:0]  last_a;
  logic        err_a;
  logic [15:0] cnt_b, sum_b;
  logic [1:0]  last_b;
  logic        err_b;

  int checks   = 0;
  int failures = 0;

  demo_top dut (
    .i_clk         (r_clk),
    .i_async_rst_n (rst_n),
    .o_xfer_cnt    (cnt_a),
    .o_sum         (sum_a),
    .o_last_data   (last_a),
    .o_err         (err_a)
  );

  demo_top #(.DATA_WIDTH(2)) dut_w (
    .i_clk         (r_clk),
    .i_async_rst_n (rst_n),
    .o_xfer_cnt    (cnt_b),
    .o_sum         (sum_b),
    .o_last_data   (last_b),
    .o_err         (err_b)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Advance n rising edges, then park on the following falling edge for sampling.
  task automatic step(input int n);
    repeat (n) @(posedge r_clk);
    @(negedge r_clk);
  endtask

  initial begin
    rst_n = 1'b0;
    step(2);
    check("hold_cnt",   32'(cnt_a),     0);
    check("hold_sum",   32'(sum_a),     0);
    check("hold_last",  32'(last_a),    0);
    check("hold_err",   32'(err_a),     0);
    check("hold_valid", 32'(dut.valid), 0);
    check("hold_cnt_w", 32'(cnt_b),     0);

    // Basic stream.
    rst_n = 1'b1;
    step(1);
    check("e1_valid", 32'(dut.valid), 1);
    check("e1_cnt",   32'(cnt_a),     0);
    step(2);
    check("pre_e4_valid", 32'(dut.valid), 1);
    check("pre_e4_ready", 32'(dut.ready), 0);
    check("pre_e4_data",  32'(dut.data),  2);
    check("e3_cnt",       32'(cnt_a),     2);
    step(1);
    check("e4_cnt_hold", 32'(cnt_a),    2);
    check("e4_data",     32'(dut.data), 2);
    check("e4_ready",    32'(dut.ready), 1);
    step(1);
    check("e5_last", 32'(last_a), 2);
    check("e5_cnt",  32'(cnt_a),  3);
    step(4);
    check("e9_cnt",    32'(cnt_a),  6);
    check("e9_sum",    32'(sum_a),  15);
    check("e9_last",   32'(last_a), 5);
    check("e9_err",    32'(err_a),  0);
    check("e9_w_sum",  32'(sum_b),  7);
    check("e9_w_last", 32'(last_b), 1);
    step(3);
    check("wrap_cnt",  32'(cnt_b),  8);
    check("wrap_sum",  32'(sum_b),  12);
    check("wrap_last", 32'(last_b), 3);
    check("wrap_err",  32'(err_b),  0);
    check("e12_cnt",   32'(cnt_a),  8);

    // Asynchronous clear between clock edges.
    rst_n = 1'b0;
    #1;
    check("arst_cnt",   32'(cnt_a),  0);
    check("arst_sum",   32'(sum_a),  0);
    check("arst_last",  32'(last_a), 0);
    check("arst_valid", 32'(dut.valid), 0);
    @(negedge r_clk);
    rst_n = 1'b1;
    step(2);
    check("r2_cnt",  32'(cnt_a),  1);
    check("r2_last", 32'(last_a), 0);

    // Mid-stream reset after edge 6.
    step(4);
    check("r6_cnt", 32'(cnt_a), 4);
    rst_n = 1'b0;
    #1;
    check("mid_cnt", 32'(cnt_a), 0);
    check("mid_sum", 32'(sum_a), 0);
    #1;
    rst_n = 1'b1;
    step(1);
    check("m1_cnt", 32'(cnt_a), 0);
    step(1);
    check("m2_cnt",  32'(cnt_a),  1);
    check("m2_last", 32'(last_a), 0);
    check("m2_err",  32'(err_a),  0);

    // Error injection: edge 6 should carry 3; drive 7 instead.
    step(3);
    check("m5_last", 32'(last_a), 2);
    check("m5_err",  32'(err_a),  0);
    force dut.data = 8'd7;
    step(1);
    release dut.data;
    check("inj_err",  32'(err_a),  1);
    check("inj_last", 32'(last_a), 7);
    check("inj_cnt",  32'(cnt_a),  4);
    step(3);
    check("sticky_err",  32'(err_a),  1);
    check("post_last",   32'(last_a), 5);
    check("post_cnt",    32'(cnt_a),  6);
    check("w_err_clean", 32'(err_b),  0);
    rst_n = 1'b0;
    #1;
    check("err_cleared", 32'(err_a), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demo_top.md
# demo_top

Self-contained simulation top block: an internal producer streams an incrementing data sequence over a valid/ready handshake to an internal consumer that stalls periodically. The consumer checks ordering, accumulates a checksum and transfer count, and raises a sticky error on any sequence mismatch. It sits directly under the simulation bench, which drives only clock and reset; status outputs exist for observation and self-checking.

## Interface
- DATA_WIDTH, 8, width of streamed data word (≥2)
- SUM_WIDTH, 16, width of checksum accumulator (≥ DATA_WIDTH)
- CNT_WIDTH, 16, width of transfer counter
- STALL_PERIOD, 4, consumer ready-pattern period in cycles (≥2); ready low for 1 cycle per period
- Clock: one clock. Reset: asynchronous, active-low.
- i_clk  in  1  clock, all logic on rising edge
- i_async_rst_n  in  1  asynchronous active-low reset
- o_xfer_cnt  out  CNT_WIDTH  number of completed handshakes, saturating
- o_sum  out  SUM_WIDTH  modulo-2^SUM_WIDTH sum of all transferred data
- o_last_data  out  DATA_WIDTH  data of most recent transfer
- o_err  out  1  sticky sequence-mismatch flag

## Operation
- Internal link: valid, ready, data[DATA_WIDTH-1:0]; transfer occurs on a rising edge where valid && ready.
- Producer: registers p_valid and p_data.
  - p_valid rises to 1 on the first edge after reset release and stays 1; it never deasserts.
  - p_data holds while valid && !ready; on transfer it increments by 1, wrapping 2^DATA_WIDTH−1 → 0.
- Consumer ready: phase counter 0..STALL_PERIOD−1, increments every edge, wraps to 0.
  - ready = (phase != STALL_PERIOD−1), combinational from phase.
- Consumer on transfer:
  - o_xfer_cnt += 1, saturating at all-ones.
  - o_sum += zero-extended data, wrapping.
  - o_last_data <= data.
  - Expected-value register exp (reset 0) compared with data; mismatch sets o_err = 1 until reset; exp increments with the same wrap rule.
- No transfer: all consumer registers hold.

## Timing
- Reset (asynchronous assert): p_valid=0, p_data=0, phase=0, exp=0, o_xfer_cnt=0, o_sum=0, o_last_data=0, o_err=0, immediately on assertion.
- Deassertion: takes effect at the next rising edge; no synchronizer inside the block, so the bench releases reset away from the clock edge.
- Edges are numbered from the first edge after release.
  - Edge 1: p_valid 0→1; phase 0→1; no transfer.
  - Edge 2 onward: transfer on every edge where phase before the edge ≠ STALL_PERIOD−1.
  - With default STALL_PERIOD=4, edges 4, 8, 12, … stall.
- All outputs are registered; they update on the same edge as the transfer, with zero added latency.
- Reset mid-stream: all state returns to reset values at once. After release the sequence restarts at 0 with the edge-1 behaviour above; no residual error.
- Wrap-around: data 2^DATA_WIDTH−1 is followed by 0 and is not an error, because exp wraps identically.

## Test plan
- Reset hold: keep reset low for 2 edges → all outputs 0, no transfers.
- Basic stream: release reset, run 9 edges (defaults) → o_xfer_cnt=6, o_sum=15, o_last_data=5, o_err=0; stalls on edges 4 and 8.
- Stall hold: sample the link at edge 4 → valid=1, ready=0, data=2 held; data=2 transfers on edge 5.
- Data wrap (DATA_WIDTH=2): run 12 edges → transferred sequence 0,1,2,3,0,1,2,3 with o_err=0; o_sum=12 after 8 transfers.
- Mid-stream reset: assert reset after edge 6, then release → outputs clear asynchronously; next first transfer carries data 0 at edge 2 after release.
- Error injection: force one producer data value to a wrong value (e.g. 7 instead of 3) for one transfer → o_err=1 from that edge and stays 1 until reset.
